// File: rtl/oam_dma_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : oam_dma_arbiter
//  Description : Shared memory bus arbiter between the CPU and the OAM DMA
//                engine. Implements the DMA register at 0xFF46. Copies
//                XFER_LEN bytes from {src_hi,8'h00} into OAM and restricts
//                the CPU to HRAM and 0xFF46 while the copy runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module oam_dma_arbiter #(
    parameter int BYTE_CYCLES = 4,
    parameter int START_DELAY = 4,
    parameter int XFER_LEN    = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_wait,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic        dma_active
);

    localparam int SLOT_MAX = (BYTE_CYCLES > START_DELAY) ? BYTE_CYCLES : START_DELAY;
    localparam int SLOT_W   = $clog2(SLOT_MAX);

    localparam logic [SLOT_W-1:0] SLOT_ZERO  = '0;
    localparam logic [SLOT_W-1:0] SLOT_ONE   = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] START_LAST = SLOT_W'(START_DELAY - 1);
    localparam logic [SLOT_W-1:0] BYTE_LAST  = SLOT_W'(BYTE_CYCLES - 1);
    localparam logic [7:0]        IDX_LAST   = 8'(XFER_LEN - 1);
    localparam logic [15:0]       DMA_ADDR   = 16'hFF46;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [7:0]        dma_reg, dma_reg_nx;
    logic [7:0]        byte_idx, byte_idx_nx;
    logic [7:0]        latch, latch_nx;
    logic [SLOT_W-1:0] slot_cnt, slot_cnt_nx;

    logic       is_dma_reg;
    logic       is_hram;
    logic       cpu_wr;
    logic       cpu_rd;
    logic       dma_wr;
    logic       slot0;
    logic       slot1;
    logic [7:0] src_hi;

    // A simultaneous read and write is treated as a write.
    assign cpu_wr     = cpu_write;
    assign cpu_rd     = cpu_read & ~cpu_write;
    assign is_dma_reg = (cpu_addr == DMA_ADDR);
    assign is_hram    = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
    assign dma_wr     = is_dma_reg & cpu_wr;
    assign slot0      = (state == XFER) && (slot_cnt == SLOT_ZERO);
    assign slot1      = (state == XFER) && (slot_cnt == SLOT_ONE);
    assign dma_active = (state != IDLE);

    // Pages 0xE0..0xFF alias down onto work RAM (echo region).
    assign src_hi = (dma_reg < 8'hE0) ? dma_reg : (dma_reg - 8'h20);

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            dma_reg  <= 8'hFF;
            byte_idx <= 8'h00;
            latch    <= 8'h00;
            slot_cnt <= SLOT_ZERO;
        end else begin
            state    <= state_nx;
            dma_reg  <= dma_reg_nx;
            byte_idx <= byte_idx_nx;
            latch    <= latch_nx;
            slot_cnt <= slot_cnt_nx;
        end
    end

    // Next-state logic: a DMA register write restarts from any state.
    always_comb begin
        state_nx    = state;
        dma_reg_nx  = dma_reg;
        byte_idx_nx = byte_idx;
        latch_nx    = latch;
        slot_cnt_nx = slot_cnt;
        if (dma_wr) begin
            dma_reg_nx  = cpu_wdata;
            state_nx    = START;
            slot_cnt_nx = SLOT_ZERO;
            byte_idx_nx = 8'h00;
        end else begin
            case (state)
                START: begin
                    if (slot_cnt == START_LAST) begin
                        state_nx    = XFER;
                        slot_cnt_nx = SLOT_ZERO;
                        byte_idx_nx = 8'h00;
                    end else begin
                        slot_cnt_nx = slot_cnt + SLOT_ONE;
                    end
                end
                XFER: begin
                    if (slot_cnt == SLOT_ZERO) begin
                        latch_nx = mem_rdata;
                    end
                    if (slot_cnt == BYTE_LAST) begin
                        slot_cnt_nx = SLOT_ZERO;
                        if (byte_idx == IDX_LAST) begin
                            state_nx    = IDLE;
                            byte_idx_nx = 8'h00;
                        end else begin
                            byte_idx_nx = byte_idx + 8'd1;
                        end
                    end else begin
                        slot_cnt_nx = slot_cnt + SLOT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bus steering: CPU pass-through, DMA slot ownership and OAM write strobe.
    always_comb begin
        cpu_rdata = mem_rdata;
        cpu_wait  = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        oam_we    = 1'b0;
        oam_addr  = 8'h00;
        oam_wdata = 8'h00;

        if (is_dma_reg) begin
            cpu_rdata = dma_reg;
        end else if (state != XFER) begin
            mem_read  = cpu_rd;
            mem_write = cpu_wr;
        end else if (is_hram) begin
            if (slot_cnt == SLOT_ZERO) begin
                cpu_wait  = cpu_rd | cpu_wr;
                cpu_rdata = 8'hFF;
            end else begin
                mem_read  = cpu_rd;
                mem_write = cpu_wr;
            end
        end else begin
            cpu_rdata = 8'hFF;
        end

        // A restart write wins over whatever the current slot would do.
        if (slot0 && !dma_wr) begin
            mem_addr  = {src_hi, byte_idx};
            mem_read  = 1'b1;
            mem_write = 1'b0;
        end
        if (slot1 && !dma_wr) begin
            oam_we    = 1'b1;
            oam_addr  = byte_idx;
            oam_wdata = latch;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oam_dma_arbiter
//  Description : Scoreboard bench for oam_dma_arbiter with a cycle-level
//                transfer model, randomized CPU traffic and memory models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oam_dma_arbiter;

    localparam int BC    = 4;
    localparam int SD    = 4;
    localparam int XL    = 160;
    localparam int TOTAL = SD + XL * BC;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_rdata;
    logic        cpu_wait;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_rdata;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic        dma_active;

    oam_dma_arbiter #(
        .BYTE_CYCLES(BC),
        .START_DELAY(SD),
        .XFER_LEN   (XL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_rdata (cpu_rdata),
        .cpu_wait  (cpu_wait),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .oam_addr  (oam_addr),
        .oam_wdata (oam_wdata),
        .oam_we    (oam_we),
        .dma_active(dma_active)
    );

    always #5 clk = ~clk;

    // Harness memories driven by the DUT
    logic [7:0] mem     [0:65535];
    logic [7:0] oam_mem [0:255];
    assign mem_rdata = mem_read ? mem[mem_addr] : 8'h00;
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] = mem_wdata;
        if (oam_we) oam_mem[oam_addr] = oam_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Reference model state
    typedef struct {
        int         cyc;
        logic [7:0] addr;
        logic [7:0] data;
    } oam_exp_t;

    oam_exp_t   oam_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] ref_mem [0:65535];
    logic [7:0] ref_oam [0:255];
    logic [7:0] ref_dma  = 8'hFF;
    bit         have     = 1'b0;
    int         w_cyc    = 0;
    int         keep_cyc = -1;
    int         checks   = 0;
    int         errors   = 0;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h9A;
    endfunction

    function automatic logic [7:0] fold(input logic [7:0] v);
        return (v >= 8'hE0) ? (v - 8'h20) : v;
    endfunction

    function automatic bit is_hram(input logic [15:0] a);
        return (a >= 16'hFF80) && (a <= 16'hFFFE);
    endfunction

    function automatic bit ref_active(input int c);
        return (have && c > w_cyc && c <= w_cyc + TOTAL) || (c == keep_cyc);
    endfunction

    function automatic bit ref_xfer(input int c);
        return have && c > w_cyc + SD && c <= w_cyc + TOTAL;
    endfunction

    function automatic bit ref_slot0(input int c);
        return ref_xfer(c) && (((c - w_cyc - SD - 1) % BC) == 0);
    endfunction

    function automatic int next_slot0(input int c);
        int s;
        s = w_cyc + SD + 1;
        if (c <= s) return s;
        return s + ((c - s + BC - 1) / BC) * BC;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Model: a DMA register write at cycle c schedules XL OAM writes
    task automatic model_start(input logic [7:0] v, input int c);
        logic [7:0] src;
        oam_exp_t   e;
        keep_cyc = ref_active(c) ? c : -1;
        while (oam_q.size() > 0 && oam_q[$].cyc >= c) void'(oam_q.pop_back());
        have    = 1'b1;
        w_cyc   = c;
        ref_dma = v;
        src     = fold(v);
        for (int i = 0; i < XL; i++) begin
            e.cyc  = c + SD + 2 + i * BC;
            e.addr = 8'(i);
            e.data = ref_mem[{src, 8'(i)}];
            oam_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_access(input bit wr, input logic [15:0] a, input logic [7:0] d,
                              input string nm);
        int k;
        int waits;
        int exp_waits;
        bit done;
        k         = cyc;
        exp_waits = (is_hram(a) && ref_slot0(k)) ? 1 : 0;
        if (!wr) begin
            if (a == 16'hFF46) rd_q.push_back(ref_dma);
            else if (ref_xfer(k) && !is_hram(a)) rd_q.push_back(8'hFF);
            else rd_q.push_back(ref_mem[a]);
        end
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_read  = !wr;
        cpu_write = wr;
        if (wr && a == 16'hFF46) model_start(d, k);
        else if (wr && (!ref_xfer(k) || is_hram(a))) ref_mem[a] = d;
        waits = 0;
        done  = 1'b0;
        for (int n = 0; n < 8 && !done; n++) begin
            @(negedge clk);
            if (n == 0 && a == 16'hFF46)
                chk({nm, " not forwarded"}, {31'd0, mem_write}, 32'd0);
            if (n == 0 && a != 16'hFF46 && !is_hram(a) && ref_xfer(k))
                chk({nm, " bus quiet"}, {30'd0, mem_write, mem_read & !ref_slot0(k)}, 32'd0);
            if (n == 0 && exp_waits == 1)
                chk({nm, " held off bus"}, {31'd0, mem_write}, 32'd0);
            if (cpu_wait) waits++;
            else done = 1'b1;
            @(posedge clk);
            #1;
        end
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        chk({nm, " wait cycles"}, waits, exp_waits);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " dma_active"}, {31'd0, dma_active}, 32'd0);
        chk({nm, " oam_we"}, {31'd0, oam_we}, 32'd0);
        chk({nm, " strobes"}, {29'd0, mem_read, mem_write, cpu_wait}, 32'd0);
        chk({nm, " oam_addr/wdata"}, {16'd0, oam_addr, oam_wdata}, 32'd0);
    endtask

    task automatic chk_oam(input string nm);
        int bad;
        bad = 0;
        for (int i = 0; i < XL; i++)
            if (oam_mem[i] !== ref_oam[i]) bad++;
        chk({nm, " mismatching bytes"}, bad, 32'd0);
    endtask

    task automatic chk_mem(input string nm);
        int bad;
        bad = 0;
        for (int a = 16'hC000; a <= 16'hDFFF; a++)
            if (mem[a] !== ref_mem[a]) bad++;
        for (int a = 16'hFF80; a <= 16'hFFFE; a++)
            if (mem[a] !== ref_mem[a]) bad++;
        chk({nm, " mismatching bytes"}, bad, 32'd0);
    endtask

    // Monitor: per-cycle activity check and scoreboard pops
    initial begin : monitor
        oam_exp_t   e;
        logic [7:0] r;
        forever begin
            @(negedge clk);
            chk("dma_active", {31'd0, dma_active}, {31'd0, ref_active(cyc)});
            while (oam_q.size() > 0 && oam_q[0].cyc < cyc) begin
                e = oam_q.pop_front();
                ref_oam[e.addr] = e.data;
                checks++;
                errors++;
                $display("FAIL oam_write missing actual=none expected cyc=%0d addr=%0h data=%0h",
                         e.cyc, e.addr, e.data);
            end
            if (oam_we) begin
                checks++;
                if (oam_q.size() == 0) begin
                    errors++;
                    $display("FAIL oam_write unexpected actual cyc=%0d addr=%0h data=%0h expected=none",
                             cyc, oam_addr, oam_wdata);
                end else begin
                    e = oam_q.pop_front();
                    ref_oam[e.addr] = e.data;
                    if (e.cyc != cyc || e.addr !== oam_addr || e.data !== oam_wdata) begin
                        errors++;
                        $display("FAIL oam_write actual cyc=%0d addr=%0h data=%0h expected cyc=%0d addr=%0h data=%0h",
                                 cyc, oam_addr, oam_wdata, e.cyc, e.addr, e.data);
                    end
                end
            end
            if (cpu_read && !cpu_write && !cpu_wait) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL cpu_read unexpected actual=%0h expected=none", cpu_rdata);
                end else begin
                    r = rd_q.pop_front();
                    if (cpu_rdata !== r) begin
                        errors++;
                        $display("FAIL cpu_read addr=%0h actual=%0h expected=%0h", cpu_addr, cpu_rdata, r);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    // Stimulus
    initial begin : stim
        int         t0;
        int         t1;
        int         sel;
        logic [15:0] a;
        logic [7:0]  d;
        reset     = 1'b1;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = pat(16'(i));
            ref_mem[i] = pat(16'(i));
        end
        for (int i = 0; i < 256; i++) begin
            oam_mem[i] = 8'h00;
            ref_oam[i] = 8'h00;
        end
        #1;
        chk_reset_outputs("initial reset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);
        cpu_access(1'b0, 16'hFF46, 8'h00, "dma_reg reset value");

        // Full transfer from 0xC000 with CPU traffic during the copy
        cpu_access(1'b1, 16'hFF46, 8'hC0, "start c0");
        t0 = w_cyc;
        wait_until(t0 + SD + 1 + 10 * BC + 2);
        cpu_access(1'b0, 16'hC010, 8'h00, "xfer read c010");
        cpu_access(1'b1, 16'hD000, 8'h77, "xfer write d000");
        cpu_access(1'b0, 16'hFF46, 8'h00, "xfer read ff46");
        wait_until(next_slot0(cyc));
        d = 8'($urandom);
        cpu_access(1'b1, 16'hFF90, d, "hram write slot0");
        wait_until(next_slot0(cyc));
        cpu_access(1'b0, 16'hFF90, 8'h00, "hram read slot0");
        for (int n = 0; n < 24; n++) begin
            sel = int'($urandom_range(0, 3));
            d   = 8'($urandom);
            case (sel)
                0: cpu_access(1'b1, 16'hFF80 + 16'($urandom_range(0, 126)), d, "rnd hram write");
                1: cpu_access(1'b0, 16'hFF80 + 16'($urandom_range(0, 126)), d, "rnd hram read");
                2: cpu_access(1'b0, 16'hC000 + 16'($urandom_range(0, 8191)), d, "rnd other read");
                default: cpu_access(1'b1, 16'hC100 + 16'($urandom_range(0, 255)), d, "rnd other write");
            endcase
            idle(int'($urandom_range(0, 2)));
        end
        wait_until(t0 + TOTAL + 2);
        chk_oam("oam after c0");
        d = 8'($urandom);
        cpu_access(1'b1, 16'hC123, d, "idle write c123");
        cpu_access(1'b0, 16'hC123, 8'h00, "idle read c123");

        // Restart to page 0xD0 after byte 50
        cpu_access(1'b1, 16'hFF46, 8'hC0, "start c0 again");
        t1 = w_cyc;
        wait_until(t1 + SD + 1 + 50 * BC + 2);
        cpu_access(1'b1, 16'hFF46, 8'hD0, "restart d0");
        t1 = w_cyc;
        wait_until(t1 + TOTAL + 2);
        chk_oam("oam after d0");

        // Echo-folded source page
        cpu_access(1'b1, 16'hFF46, 8'hF1, "start f1");
        t1 = w_cyc;
        wait_until(t1 + TOTAL + 2);
        chk_oam("oam after f1");
        cpu_access(1'b0, 16'hFF46, 8'h00, "read ff46 f1");

        // Reset at byte 80
        cpu_access(1'b1, 16'hFF46, 8'hC0, "start c0 for reset");
        t1 = w_cyc;
        wait_until(t1 + SD + 1 + 80 * BC);
        #1;
        reset    = 1'b1;
        have     = 1'b0;
        keep_cyc = -1;
        ref_dma  = 8'hFF;
        while (oam_q.size() > 0 && oam_q[$].cyc >= cyc) void'(oam_q.pop_back());
        #1;
        chk_reset_outputs("async reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(4);
        chk_oam("oam after reset");
        cpu_access(1'b0, 16'hC000, 8'h00, "post reset read c000");
        cpu_access(1'b0, 16'hFF46, 8'h00, "post reset read ff46");
        idle(3);
        chk("oam queue drained", oam_q.size(), 32'd0);
        chk("read queue drained", rd_q.size(), 32'd0);
        chk_mem("memory image");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
